// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result handshake bundle for pipelined_add_sub
// Purpose: groups the upstream operand beat and downstream result beat of the
//   pipelined add/subtract unit into one interface.
// Signals:
//   in_valid_i / in_ready_o   operand beat handshake
//   a_i, b_i, cin_i, sub_i    operands, carry-in, subtract select
//   out_valid_o / out_ready_i result beat handshake
//   sum_o, cout_o, ovf_o, zero_o  result and flags
// Modports: master drives operands and result-ready, slave is the unit.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;

  modport master (
    output in_valid_i, a_i, b_i, cin_i, sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, zero_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, sub_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined add/subtract unit with carry, overflow and zero flags
// Purpose: computes {cout,sum} = A + (B ^ {WIDTH{sub}}) + cin over STAGES
//   cycles, resolving one WIDTH/STAGES-bit segment per stage with the carry
//   held in pipeline registers between segments.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset, clears every stage
//   bus    pipelined_add_sub_if.slave: operand beat in, result beat out
// Parameters: WIDTH operand width, STAGES pipeline depth (WIDTH % STAGES == 0).
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipelined_add_sub_if.slave bus
);

  localparam int STG_SAFE = (STAGES > 0) ? STAGES : 1;
  localparam int SEG      = WIDTH / STG_SAFE;

  if (STAGES < 1 || (WIDTH % STG_SAFE) != 0) begin : g_param_check
    $error("pipelined_add_sub: STAGES must be >= 1 and divide WIDTH");
  end

  logic             w_adv;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_b_mod;

  assign w_b_mod = bus.b_i ^ {WIDTH{bus.sub_i}};

  // Global advance: the whole pipe moves or the whole pipe holds.
  assign w_adv = ~w_out_valid | bus.out_ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unresolved after this stage has added its segment.
    localparam int REM = WIDTH - (k + 1) * SEG;

    logic [SEG-1:0]         w_a_seg;
    logic [SEG-1:0]         w_b_seg;
    logic                   w_c_in;
    logic                   w_v_in;
    logic                   w_as_in;
    logic                   w_bs_in;
    logic [SEG:0]           w_seg;
    logic [(k+1)*SEG-1:0]   r_sum;
    logic                   r_c;
    logic                   r_v;
    logic                   r_as;
    logic                   r_bs;

    if (k == 0) begin : g_src
      assign w_a_seg = bus.a_i[SEG-1:0];
      assign w_b_seg = w_b_mod[SEG-1:0];
      assign w_c_in  = bus.cin_i;
      assign w_v_in  = bus.in_valid_i;
      assign w_as_in = bus.a_i[WIDTH-1];
      assign w_bs_in = w_b_mod[WIDTH-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_sum <= '0;
        else if (w_adv) r_sum <= w_seg[SEG-1:0];
      end
    end else begin : g_src
      // Remaining operands are kept right-aligned, so this stage's segment
      // is always the low SEG bits of its predecessor's operand registers.
      assign w_a_seg = g_stage[k-1].g_rem.r_a[SEG-1:0];
      assign w_b_seg = g_stage[k-1].g_rem.r_b[SEG-1:0];
      assign w_c_in  = g_stage[k-1].r_c;
      assign w_v_in  = g_stage[k-1].r_v;
      assign w_as_in = g_stage[k-1].r_as;
      assign w_bs_in = g_stage[k-1].r_bs;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_sum <= '0;
        else if (w_adv) r_sum <= {w_seg[SEG-1:0], g_stage[k-1].r_sum};
      end
    end

    assign w_seg = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEG{1'b0}}, w_c_in};

    // Operand sign bits ride along so the last stage can form the signed
    // overflow flag from A and B' rather than from the raw B input.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_c  <= 1'b0;
        r_v  <= 1'b0;
        r_as <= 1'b0;
        r_bs <= 1'b0;
      end else if (w_adv) begin
        r_c  <= w_seg[SEG];
        r_v  <= w_v_in;
        r_as <= w_as_in;
        r_bs <= w_bs_in;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;

      if (k == 0) begin : g_load
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_adv) begin
            r_a <= bus.a_i[WIDTH-1:SEG];
            r_b <= w_b_mod[WIDTH-1:SEG];
          end
        end
      end else begin : g_load
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_adv) begin
            r_a <= g_stage[k-1].g_rem.r_a[REM+SEG-1:SEG];
            r_b <= g_stage[k-1].g_rem.r_b[REM+SEG-1:SEG];
          end
        end
      end
    end
  end

  assign w_out_valid     = g_stage[STAGES-1].r_v;
  assign bus.out_valid_o = w_out_valid;
  assign bus.in_ready_o  = w_adv;
  assign bus.sum_o       = g_stage[STAGES-1].r_sum;
  assign bus.cout_o      = g_stage[STAGES-1].r_c;
  assign bus.ovf_o       = ~(g_stage[STAGES-1].r_as ^ g_stage[STAGES-1].r_bs)
                         & (g_stage[STAGES-1].r_as ^ g_stage[STAGES-1].r_sum[WIDTH-1]);
  // Gated by valid so the flag reads 0 out of reset and on bubbles.
  assign bus.zero_o      = w_out_valid & ~|g_stage[STAGES-1].r_sum;

endmodule
